// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e : responder FSM encoding (IDLE / WAIT / RESP)
//   dec_e   : address-decode outcome for a latched request
//   WCNT_W  : width of the wait-state down-counter (WAIT_CYCLES 0..15)
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DEC_RAM = 2'd0,
    DEC_CNT = 2'd1,
    DEC_ERR = 2'd2
  } dec_e;

  localparam int WCNT_W = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the processor datapath (master) and the
// data-memory responder (slave).
//   mem_read/mem_write/addr/wdata : request, held by the core until ready
//   rdata/err                     : response, held until the next response
//   ready                         : one-cycle completion pulse
//   stall                         : pipeline hold while a request is pending
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/data_mem_responder_word_ram.sv
// DEPTH x 32 word RAM: synchronous write, asynchronous read. Contents are
// deliberately not reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address
//   rdata_o : read data (combinational)
module word_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Word write on the rising edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory interface. Serves word loads and
// stores from an internal RAM or a read-only free-running cycle counter,
// inserting WAIT_CYCLES wait states before a one-cycle ready pulse.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of the load/store bus (see data_mem_responder_if)
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] CNT_ADDR    = 32'hFFFF_FFF0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_LD  = WCNT_W'(WAIT_CYCLES);
  localparam bit                HAS_WAIT = (WAIT_CYCLES > 0);

  state_e              state_q, state_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d, err_q, err_d;
  logic [31:0]         cnt_q;

  logic                src_rd_s, src_wr_s;
  logic [31:0]         src_addr_s;
  dec_e                dec_s;
  logic [31:0]         ram_rdata_s, resp_rdata_s;
  logic                resp_err_s, ram_we_s;

  // Request source: with zero wait states RESP is entered straight from IDLE,
  // before the latch is loaded, so decode the live bus in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      src_rd_s   = bus.mem_read;
      src_wr_s   = bus.mem_write;
      src_addr_s = bus.addr;
    end else begin
      src_rd_s   = rd_q;
      src_wr_s   = wr_q;
      src_addr_s = addr_q;
    end
  end

  // Priority address decode of the request being answered.
  always_comb begin
    dec_s = DEC_ERR;
    if (src_rd_s && src_wr_s) begin
      dec_s = DEC_ERR;
    end else if (src_addr_s[1:0] != 2'b00) begin
      dec_s = DEC_ERR;
    end else if (src_addr_s == CNT_ADDR) begin
      dec_s = DEC_CNT;
    end else if ({2'b00, src_addr_s[31:2]} < 32'(DEPTH)) begin
      dec_s = DEC_RAM;
    end else begin
      dec_s = DEC_ERR;
    end
  end

  // Response payload; stores and failed accesses return zero data.
  always_comb begin
    resp_rdata_s = 32'h0000_0000;
    resp_err_s   = 1'b1;
    case (dec_s)
      DEC_RAM: begin
        resp_err_s   = 1'b0;
        resp_rdata_s = src_rd_s ? ram_rdata_s : 32'h0000_0000;
      end
      DEC_CNT: begin
        resp_err_s   = 1'b0;
        resp_rdata_s = src_rd_s ? cnt_q : 32'h0000_0000;
      end
      DEC_ERR: begin
        resp_err_s   = 1'b1;
        resp_rdata_s = 32'h0000_0000;
      end
      default: begin
        resp_err_s   = 1'b1;
        resp_rdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Store commits on the edge leaving RESP, so a reset during the wait
  // discards it.
  assign ram_we_s = (state_q == RESP) && wr_q && !rd_q && (dec_s == DEC_RAM);

  word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .raddr_i (src_addr_s[AW+1:2]),
    .rdata_o (ram_rdata_s)
  );

  // FSM next-state and response loading.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          rd_d    = bus.mem_read;
          wr_d    = bus.mem_write;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wcnt_d  = WAIT_LD;
          if (HAS_WAIT) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            rdata_d = resp_rdata_s;
            err_d   = resp_err_s;
            ready_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          state_d = RESP;
          rdata_d = resp_rdata_s;
          err_d   = resp_err_s;
          ready_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wcnt_q  <= '0;
      rdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'h0000_0000;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.stall = (bus.mem_read | bus.mem_write) & ~ready_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory load/store interface.
- Accepts mem_read/mem_write requests from the MIPS datapath and serves them from an internal word RAM or a memory-mapped cycle counter.
- Applies a programmable number of wait states and signals completion with ready.
- Drives stall back to the core so the PC and register file hold until the access completes.

Parameters:
- DEPTH, 256, number of 32-bit words in the internal RAM; power of two, at least 4.
- WAIT_CYCLES, 2, wait states inserted before the response; legal range 0..15.
- CNT_ADDR, 32'hFFFF_FFF0, byte address of the read-only cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request; held by the core until ready.
- mem_write  in  1  store request; held by the core until ready.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (register-file read port 2).
- rdata  out  32  load data; valid while ready=1 and held until the next response.
- ready  out  1  one-cycle completion pulse.
- stall  out  1  combinational: (mem_read|mem_write) & ~ready.
- err  out  1  error flag for the completed access; valid with ready and held until the next response.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - rdata=0, ready=0, err=0, cycle counter=0.
  - A write in flight is not committed. RAM contents are not reset.
- Cycle counter:
  - Free-running 32 bits, +1 every clk.
  - Wraps from 32'hFFFF_FFFF to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On mem_read|mem_write, latch op, addr and wdata, and load wcnt=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - With no request, stay in IDLE.
- WAIT:
  - wcnt decrements each cycle; go to RESP when wcnt==1.
  - Input changes during WAIT are ignored; the latched request is used.
- Entry into RESP (registered on the transition edge):
  - Decode the latched request and load rdata/err.
  - ready=1 for exactly the RESP cycle.
- RESP:
  - A valid store commits to RAM at the clock edge leaving RESP.
  - Next state is always IDLE. ready returns to 0.
- Latency: request seen in IDLE at cycle 0 gives ready=1 at cycle WAIT_CYCLES+1.
- Back-to-back: a request present in the IDLE cycle after RESP starts a new transaction. Minimum spacing is WAIT_CYCLES+2 cycles.
- Decode (priority order):
  1. mem_read and mem_write both high: err=1, no access, rdata=0.
  2. addr[1:0]!=0 (misaligned): err=1, no access, rdata=0.
  3. addr==CNT_ADDR: a read returns the counter value sampled on the RESP-entry edge. A write is ignored with err=0.
  4. addr[31:2] < DEPTH: read returns RAM[addr[31:2]]; write stores wdata. err=0.
  5. Otherwise: err=1, no access, rdata=0.
- Read-after-write to the same word in consecutive transactions returns the new data; the write committed before the next RESP entry.
- Only full 32-bit word accesses are supported; there are no byte enables.

Decomposition:
- Package data_mem_resp_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - decode result codes (DEC_RAM, DEC_CNT, DEC_ERR);
  - the WAIT_CYCLES counter width constant (4).
- One sub-module, word_ram: DEPTH x 32, synchronous write, asynchronous read, log2(DEPTH) address width.
- The FSM, decode and counter stay in data_mem_responder.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT of a store to addr 0x10, then release and read 0x10. The read returns the pre-store value; rdata, ready and err were 0 during reset.
- Store/load: with WAIT_CYCLES=2, write 0xDEADBEEF to 0x20, then read 0x20. ready rises 3 cycles after each request, rdata=0xDEADBEEF, err=0, stall is high for exactly 3 cycles per access.
- Zero wait: with WAIT_CYCLES=0, read 0x0 after storing 0x12345678. ready rises 1 cycle after the request; back-to-back reads are spaced by 2 cycles.
- Errors, each giving err=1, rdata=0 and RAM unchanged:
  - read at 0x22 (misaligned);
  - write at DEPTH*4 = 0x400 (out of range);
  - mem_read=mem_write=1 at 0x0.
- Counter: two reads of CNT_ADDR separated by N idle cycles return values differing by exactly N+WAIT_CYCLES+2. A write to CNT_ADDR gives err=0 and does not change the counter.
- Wrap: force the counter to 32'hFFFF_FFFE and read CNT_ADDR over successive cycles. The value passes through 32'hFFFF_FFFF to 0 without error.
